// File: rtl/btn_pulse_pkg.sv
// Shared definitions for the stopwatch button front end.
//   chan_state_e          : 2-bit channel FSM encoding
//                           (RELEASED=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3)
//   DebounceCyclesDefault : default debounce length (1 ms at 100 MHz)
package btn_pulse_pkg;

  localparam int unsigned DebounceCyclesDefault = 100000;

  typedef enum logic [1:0] {
    Released    = 2'd0,
    PressWait   = 2'd1,
    Pressed     = 2'd2,
    ReleaseWait = 2'd3
  } chan_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchronizer chain, debounce FSM and counter.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous active-high reset
//   btn_raw in  asynchronous raw button level, active-high
//   accept  out combinational, high on the edge a press is qualified
//   level   out debounced level, 1 in PRESSED or RELEASE_WAIT
module debounce_channel
  import btn_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned CNT_W           = 17,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic accept,
  output logic level
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  chan_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Saturating increment; in practice the counter is cleared on every state
  // change so it never reaches the top.
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      Released: begin
        if (sync_bit) begin
          state_d = PressWait;
          cnt_d   = '0;
        end
      end
      PressWait: begin
        if (!sync_bit) begin
          state_d = Released;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = Pressed;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      Pressed: begin
        if (!sync_bit) begin
          state_d = ReleaseWait;
          cnt_d   = '0;
        end
      end
      ReleaseWait: begin
        if (sync_bit) begin
          // Bounce during release: back to held, no new pulse.
          state_d = Pressed;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = Released;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  // Restart in PRESSED so a button held through reset must be released first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= Pressed;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = (state_q == Pressed) || (state_q == ReleaseWait);

endmodule

// File: rtl/btn_pulse_gen.sv
// Stopwatch button front end: debounces the trig and split buttons and emits
// one registered single-cycle strobe per qualified press.
// Ports:
//   clk           in  system clock
//   reset         in  synchronous active-high reset
//   btn_trig_raw  in  raw start/stop button
//   btn_split_raw in  raw split/clear button
//   trig          out one-cycle strobe per accepted trig press
//   split         out one-cycle strobe per accepted split press
//   btn_level     out debounced levels, [1]=split, [0]=trig
module btn_pulse_gen
  import btn_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned CNT_W           = 17,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_trig_raw,
  input  logic       btn_split_raw,
  output logic       trig,
  output logic       split,
  output logic [1:0] btn_level
);

  logic acc_trig, acc_split;
  logic lvl_trig, lvl_split;
  logic trig_q, trig_d;
  logic split_q, split_d;
  logic pending_q, pending_d;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_trig_ch (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_trig_raw),
    .accept (acc_trig),
    .level  (lvl_trig)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_split_ch (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_split_raw),
    .accept (acc_split),
    .level  (lvl_split)
  );

  // Trig wins a same-edge tie; split is deferred one cycle via pending.
  // A split re-accept while pending is impossible for DEBOUNCE_CYCLES >= 2.
  always_comb begin
    trig_d    = acc_trig;
    split_d   = pending_q | (acc_split & ~acc_trig);
    pending_d = acc_split & acc_trig;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q    <= 1'b0;
      split_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      trig_q    <= trig_d;
      split_q   <= split_d;
      pending_q <= pending_d;
    end
  end

  assign trig      = trig_q;
  assign split     = split_q;
  assign btn_level = {lvl_split, lvl_trig};

endmodule

// File: tb/tb_btn_pulse_gen.sv
module tb_btn_pulse_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_trig_raw = 1'b0;
  logic       btn_split_raw = 1'b0;
  logic       trig, split;
  logic [1:0] btn_level;

  int checks = 0;
  int errors = 0;
  int trig_cnt = 0;
  int split_cnt = 0;
  int overlap_cnt = 0;

  always #5 clk = ~clk;

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (17),
    .SYNC_STAGES    (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_trig_raw (btn_trig_raw),
    .btn_split_raw(btn_split_raw),
    .trig         (trig),
    .split        (split),
    .btn_level    (btn_level)
  );

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (trig === 1'b1) trig_cnt++;
    if (split === 1'b1) split_cnt++;
    if (trig === 1'b1 && split === 1'b1) overlap_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    trig_cnt = 0;
    split_cnt = 0;
    overlap_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_trig_raw = 1'b0;
    btn_split_raw = 1'b0;
    tick(2);
    checks++;
    if (trig !== 1'b0) begin errors++; $display("FAIL reset_trig got %b want 0", trig); end
    checks++;
    if (split !== 1'b0) begin errors++; $display("FAIL reset_split got %b want 0", split); end
    checks++;
    if (btn_level !== 2'b11) begin
      errors++; $display("FAIL reset_level got %b want 11", btn_level);
    end
    reset = 1'b0;
    clear_counts();
    tick(4);
    checks++;
    if (btn_level !== 2'b11) begin
      errors++; $display("FAIL release_wait_level got %b want 11", btn_level);
    end
    tick(1);
    checks++;
    if (btn_level !== 2'b00) begin
      errors++; $display("FAIL released_level got %b want 00", btn_level);
    end
    tick(5);
    checks++;
    if (trig_cnt + split_cnt !== 0) begin
      errors++; $display("FAIL release_no_pulse got %0d want 0", trig_cnt + split_cnt);
    end
  endtask

  task automatic test_single_press();
    clear_counts();
    btn_trig_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      checks++;
      if (trig !== (i == 7)) begin
        errors++; $display("FAIL press_latency tick %0d got %b want %b", i, trig, (i == 7));
      end
    end
    checks++;
    if (btn_level[0] !== 1'b1) begin
      errors++; $display("FAIL press_level got %b want 1", btn_level[0]);
    end
    tick(12);
    checks++;
    if (trig_cnt !== 1) begin errors++; $display("FAIL held_one_pulse got %0d want 1", trig_cnt); end
    btn_trig_raw = 1'b0;
    tick(10);
    checks++;
    if (btn_level[0] !== 1'b0) begin
      errors++; $display("FAIL release_level got %b want 0", btn_level[0]);
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    for (int r = 0; r < 5; r++) begin
      btn_trig_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        checks++;
        if (btn_level[0] !== 1'b0) begin
          errors++; $display("FAIL glitch_level got %b want 0", btn_level[0]);
        end
      end
      btn_trig_raw = 1'b0;
      tick(3);
    end
    tick(6);
    checks++;
    if (trig_cnt !== 0) begin errors++; $display("FAIL glitch_pulse got %0d want 0", trig_cnt); end
    checks++;
    if (btn_level[0] !== 1'b0) begin
      errors++; $display("FAIL glitch_final_level got %b want 0", btn_level[0]);
    end
  endtask

  task automatic test_split_bounce();
    clear_counts();
    btn_split_raw = 1'b1;
    tick(20);
    checks++;
    if (split_cnt !== 1 || trig_cnt !== 0) begin
      errors++; $display("FAIL split_press got split %0d trig %0d want 1 0", split_cnt, trig_cnt);
    end
    btn_split_raw = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      btn_split_raw = 1'b1;
      tick(1);
      btn_split_raw = 1'b0;
      tick(1);
    end
    tick(10);
    checks++;
    if (split_cnt !== 1) begin errors++; $display("FAIL split_bounce got %0d want 1", split_cnt); end
    checks++;
    if (btn_level[1] !== 1'b0) begin
      errors++; $display("FAIL split_release_level got %b want 0", btn_level[1]);
    end
    btn_split_raw = 1'b1;
    tick(20);
    checks++;
    if (split_cnt !== 2) begin errors++; $display("FAIL split_repress got %0d want 2", split_cnt); end
    btn_split_raw = 1'b0;
    tick(10);
  endtask

  task automatic test_simultaneous();
    clear_counts();
    btn_trig_raw = 1'b1;
    btn_split_raw = 1'b1;
    tick(7);
    checks++;
    if (trig !== 1'b1 || split !== 1'b0) begin
      errors++; $display("FAIL simul_first got trig %b split %b want 1 0", trig, split);
    end
    tick(1);
    checks++;
    if (trig !== 1'b0 || split !== 1'b1) begin
      errors++; $display("FAIL simul_second got trig %b split %b want 0 1", trig, split);
    end
    tick(10);
    checks++;
    if (overlap_cnt !== 0 || trig_cnt !== 1 || split_cnt !== 1) begin
      errors++;
      $display("FAIL simul_counts got ovl %0d trig %0d split %0d want 0 1 1",
               overlap_cnt, trig_cnt, split_cnt);
    end
    btn_trig_raw = 1'b0;
    btn_split_raw = 1'b0;
    tick(10);
  endtask

  task automatic test_held_through_reset();
    clear_counts();
    btn_trig_raw = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(30);
    checks++;
    if (trig_cnt !== 0) begin errors++; $display("FAIL held_reset_pulse got %0d want 0", trig_cnt); end
    checks++;
    if (btn_level[0] !== 1'b1) begin
      errors++; $display("FAIL held_reset_level got %b want 1", btn_level[0]);
    end
    btn_trig_raw = 1'b0;
    tick(6);
    btn_trig_raw = 1'b1;
    tick(20);
    checks++;
    if (trig_cnt !== 1) begin errors++; $display("FAIL after_reset_press got %0d want 1", trig_cnt); end
    btn_trig_raw = 1'b0;
    tick(10);
  endtask

  task automatic test_reset_mid();
    // Reset lands on the accept edge: nothing may pulse.
    clear_counts();
    btn_trig_raw = 1'b1;
    btn_split_raw = 1'b1;
    tick(6);
    reset = 1'b1;
    tick(1);
    checks++;
    if (trig !== 1'b0 || split !== 1'b0) begin
      errors++; $display("FAIL reset_on_accept got trig %b split %b want 0 0", trig, split);
    end
    tick(1);
    reset = 1'b0;
    tick(20);
    checks++;
    if (trig_cnt !== 0 || split_cnt !== 0) begin
      errors++; $display("FAIL reset_on_accept_after got trig %0d split %0d want 0 0",
                         trig_cnt, split_cnt);
    end
    // Reset while split is pending: the deferred split is dropped.
    btn_trig_raw = 1'b0;
    btn_split_raw = 1'b0;
    tick(10);
    clear_counts();
    btn_trig_raw = 1'b1;
    btn_split_raw = 1'b1;
    tick(7);
    reset = 1'b1;
    tick(1);
    checks++;
    if (trig !== 1'b0 || split !== 1'b0) begin
      errors++; $display("FAIL reset_pending got trig %b split %b want 0 0", trig, split);
    end
    reset = 1'b0;
    tick(20);
    checks++;
    if (trig_cnt !== 1 || split_cnt !== 0) begin
      errors++; $display("FAIL reset_pending_after got trig %0d split %0d want 1 0",
                         trig_cnt, split_cnt);
    end
    btn_trig_raw = 1'b0;
    btn_split_raw = 1'b0;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_split_bounce();
    test_simultaneous();
    test_held_through_reset();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
